alu_issue_ctrl: RTL and testbench

//  Initiator side of the ripple-ALU op interface. Accepts R-type requests on a

---
 rtl/alu_issue_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the multicycle ripple ALU: decodes R-type funct, holds operands
// for ALU_LAT cycles, then returns result/flags. Optional overflow trap: ALU_OVF_TRAP_EN.
module alu_issue_ctrl #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned ALU_LAT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [5:0]       req_funct,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_res,
  input  logic             alu_v,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_res,
  output logic             rsp_ovf,
  output logic             rsp_zero,
  output logic             rsp_ill
`ifdef ALU_OVF_TRAP_EN
  ,
  output logic             rsp_trap
`endif
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StExec = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  localparam logic [2:0] OpAnd = 3'b000;
  localparam logic [2:0] OpOr  = 3'b001;
  localparam logic [2:0] OpAdd = 3'b010;
  localparam logic [2:0] OpXor = 3'b011;
  localparam logic [2:0] OpNor = 3'b101;
  localparam logic [2:0] OpSub = 3'b110;
  localparam logic [2:0] OpSlt = 3'b111;

  localparam logic [3:0] CntLoad = 4'(ALU_LAT - 1);

  logic [1:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [2:0]       alu_op_q, alu_op_d;
  logic             signed_q, signed_d;
  logic [WIDTH-1:0] rsp_res_q, rsp_res_d;
  logic             rsp_ovf_q, rsp_ovf_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic             rsp_ill_q, rsp_ill_d;

  logic [2:0] dec_op;
  logic       dec_legal;
  logic       dec_signed;
  logic       cap_ovf;
  logic       cap_trap;
  logic       capture;

  always_comb begin
    dec_op     = OpAnd;
    dec_legal  = 1'b1;
    dec_signed = 1'b0;
    unique case (req_funct)
      6'h20:   begin dec_op = OpAdd; dec_signed = 1'b1; end
      6'h21:   dec_op = OpAdd;
      6'h22:   begin dec_op = OpSub; dec_signed = 1'b1; end
      6'h23:   dec_op = OpSub;
      6'h24:   dec_op = OpAnd;
      6'h25:   dec_op = OpOr;
      6'h26:   dec_op = OpXor;
      6'h27:   dec_op = OpNor;
      6'h2A:   dec_op = OpSlt;
      default: dec_legal = 1'b0;
    endcase
  end

  // Only add/sub (not the unsigned forms) report overflow.
  assign cap_ovf = signed_q & alu_v;
`ifdef ALU_OVF_TRAP_EN
  assign cap_trap = cap_ovf;
`else
  assign cap_trap = 1'b0;
`endif

  assign capture = (state_q == StExec) && (cnt_q == 4'd0);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_op_d   = alu_op_q;
    signed_d   = signed_q;
    rsp_res_d  = rsp_res_q;
    rsp_ovf_d  = rsp_ovf_q;
    rsp_zero_d = rsp_zero_q;
    rsp_ill_d  = rsp_ill_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          cnt_d = CntLoad;
          if (dec_legal) begin
            alu_a_d  = req_a;
            alu_b_d  = req_b;
            alu_op_d = dec_op;
            signed_d = dec_signed;
            state_d  = StExec;
          end else begin
            // Illegal funct skips the ALU; operands and op stay as they were.
            rsp_res_d  = '0;
            rsp_ovf_d  = 1'b0;
            rsp_zero_d = 1'b1;
            rsp_ill_d  = 1'b1;
            state_d    = StResp;
          end
        end
      end
      StExec: begin
        if (capture) begin
          rsp_res_d  = cap_trap ? '0 : alu_res;
          rsp_ovf_d  = cap_ovf;
          rsp_zero_d = (rsp_res_d == '0);
          rsp_ill_d  = 1'b0;
          state_d    = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= 3'b000;
      signed_q   <= 1'b0;
      rsp_res_q  <= '0;
      rsp_ovf_q  <= 1'b0;
      rsp_zero_q <= 1'b0;
      rsp_ill_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      signed_q   <= signed_d;
      rsp_res_q  <= rsp_res_d;
      rsp_ovf_q  <= rsp_ovf_d;
      rsp_zero_q <= rsp_zero_d;
      rsp_ill_q  <= rsp_ill_d;
    end
  end

`ifdef ALU_OVF_TRAP_EN
  logic rsp_trap_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_trap_q <= 1'b0;
    end else if (state_q == StIdle && req_valid) begin
      rsp_trap_q <= 1'b0;
    end else if (capture) begin
      rsp_trap_q <= cap_trap;
    end
  end

  assign rsp_trap = rsp_trap_q;
`endif

  assign req_ready = rst_n && (state_q == StIdle);
  assign rsp_valid = (state_q == StResp);
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign rsp_res   = rsp_res_q;
  assign rsp_ovf   = rsp_ovf_q;
  assign rsp_zero  = rsp_zero_q;
  assign rsp_ill   = rsp_ill_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: table of R-type vectors through a scoreboard queue, plus
// backpressure and mid-operation reset sequences. Follows ALU_OVF_TRAP_EN if defined.
module tb_alu_issue_ctrl;

  localparam int W   = 32;
  localparam int LAT = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic [5:0]   req_funct;
  logic [W-1:0] req_a, req_b;
  logic [W-1:0] alu_a, alu_b;
  logic [2:0]   alu_op;
  logic [W-1:0] alu_res;
  logic         alu_v;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_res;
  logic         rsp_ovf, rsp_zero, rsp_ill;
  logic         rsp_trap;

  alu_issue_ctrl #(.WIDTH(W), .ALU_LAT(LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_funct (req_funct),
    .req_a     (req_a),
    .req_b     (req_b),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_res   (alu_res),
    .alu_v     (alu_v),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_res   (rsp_res),
    .rsp_ovf   (rsp_ovf),
    .rsp_zero  (rsp_zero),
    .rsp_ill   (rsp_ill)
`ifdef ALU_OVF_TRAP_EN
    ,
    .rsp_trap  (rsp_trap)
`endif
  );

`ifndef ALU_OVF_TRAP_EN
  assign rsp_trap = 1'b0;
`endif

  always #5 clk = ~clk;

  // Behavioural slice-chain ALU.
  always_comb begin
    alu_res = '0;
    alu_v   = 1'b0;
    case (alu_op)
      3'b000: alu_res = alu_a & alu_b;
      3'b001: alu_res = alu_a | alu_b;
      3'b010: begin
        alu_res = alu_a + alu_b;
        alu_v   = (alu_a[W-1] == alu_b[W-1]) && (alu_res[W-1] != alu_a[W-1]);
      end
      3'b011: alu_res = alu_a ^ alu_b;
      3'b101: alu_res = ~(alu_a | alu_b);
      3'b110: begin
        alu_res = alu_a - alu_b;
        alu_v   = (alu_a[W-1] != alu_b[W-1]) && (alu_res[W-1] != alu_a[W-1]);
      end
      3'b111: alu_res = {{(W-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
      default: alu_res = '0;
    endcase
  end

  typedef struct {
    logic [5:0]   funct;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         ovf;
    logic         ill;
    logic [2:0]   op;
  } vec_t;

  typedef struct {
    logic [W-1:0] res;
    logic         ovf;
    logic         zero;
    logic         ill;
    logic         trap;
    int           lat;
  } exp_t;

  vec_t vecs[14];
  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;
  logic [2:0] last_op;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic exp_t make_exp(input vec_t v);
    exp_t e;
    e.ovf  = v.ovf;
    e.ill  = v.ill;
`ifdef ALU_OVF_TRAP_EN
    e.trap = v.ovf;
    e.res  = v.ovf ? '0 : v.res;
`else
    e.trap = 1'b0;
    e.res  = v.res;
`endif
    e.zero = (e.res == '0);
    e.lat  = v.ill ? 1 : LAT + 1;
    return e;
  endfunction

  // Drive one request at a negedge; returns after the accepting posedge + half cycle.
  task automatic issue(input vec_t v);
    req_funct = v.funct;
    req_a     = v.a;
    req_b     = v.b;
    req_valid = 1'b1;
    chk("req_ready_idle", W'(req_ready), W'(1));
    sbq.push_back(make_exp(v));
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Wait for rsp_valid (already one negedge past accept), pop and compare.
  task automatic collect(input string tag);
    int   n = 1;
    exp_t e;
    while (!rsp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_valid) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got no rsp_valid expected response", tag);
      return;
    end
    if (sbq.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s_unexpected: got response expected none", tag);
      return;
    end
    e = sbq.pop_front();
    chk({tag, "_lat"},  W'(n),        W'(e.lat));
    chk({tag, "_res"},  rsp_res,      e.res);
    chk({tag, "_ovf"},  W'(rsp_ovf),  W'(e.ovf));
    chk({tag, "_zero"}, W'(rsp_zero), W'(e.zero));
    chk({tag, "_ill"},  W'(rsp_ill),  W'(e.ill));
    chk({tag, "_trap"}, W'(rsp_trap), W'(e.trap));
  endtask

  initial begin
    vecs[0]  = '{6'h20, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1, 1'b0, 3'b010};
    vecs[1]  = '{6'h21, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 3'b010};
    vecs[2]  = '{6'h2A, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 3'b111};
    vecs[3]  = '{6'h22, 32'h00000005, 32'h00000005, 32'h00000000, 1'b0, 1'b0, 3'b110};
    vecs[4]  = '{6'h3F, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b0, 1'b1, 3'b110};
    vecs[5]  = '{6'h24, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 3'b000};
    vecs[6]  = '{6'h25, 32'h0F0F0000, 32'h000000FF, 32'h0F0F00FF, 1'b0, 1'b0, 3'b001};
    vecs[7]  = '{6'h26, 32'hFFFF0000, 32'hFF00FF00, 32'h00FFFF00, 1'b0, 1'b0, 3'b011};
    vecs[8]  = '{6'h27, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'h00000000, 1'b0, 1'b0, 3'b101};
    vecs[9]  = '{6'h00, 32'h00000001, 32'h00000001, 32'h00000000, 1'b0, 1'b1, 3'b101};
    vecs[10] = '{6'h23, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0, 3'b110};
    vecs[11] = '{6'h22, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b0, 3'b110};
    vecs[12] = '{6'h2A, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0, 3'b111};
    vecs[13] = '{6'h20, 32'h00000001, 32'h00000002, 32'h00000003, 1'b0, 1'b0, 3'b010};

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_funct = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", W'(req_ready), W'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req_ready_rel", W'(req_ready), W'(1));
    chk("rst_rsp_valid", W'(rsp_valid), W'(0));
    chk("rst_rsp_res",   rsp_res,       '0);
    chk("rst_alu_a",     alu_a,         '0);
    chk("rst_alu_op",    W'(alu_op),    W'(0));
    chk("rst_flags", W'({rsp_ovf, rsp_zero, rsp_ill, rsp_trap}), W'(0));
    last_op = 3'b000;

    for (int i = 0; i < 14; i++) begin
      issue(vecs[i]);
      chk($sformatf("v%0d_alu_op", i), W'(alu_op), W'(vecs[i].ill ? last_op : vecs[i].op));
      if (!vecs[i].ill) begin
        chk($sformatf("v%0d_alu_a", i), alu_a, vecs[i].a);
        last_op = vecs[i].op;
      end
      collect($sformatf("v%0d", i));
      @(negedge clk);
      chk($sformatf("v%0d_rsp_drop", i), W'(rsp_valid), W'(0));
    end

    // Backpressure: response held 4 cycles, a competing request is ignored meanwhile.
    begin
      logic [W-1:0] held_res;
      logic [3:0]   held_flags;
      vec_t bp = '{6'h21, 32'h00000010, 32'h00000020, 32'h00000030, 1'b0, 1'b0, 3'b010};
      vec_t nx = '{6'h26, 32'h0000FFFF, 32'h00FF00FF, 32'h00FFFF00, 1'b0, 1'b0, 3'b011};
      rsp_ready = 1'b0;
      issue(bp);
      collect("bp");
      held_res   = rsp_res;
      held_flags = {rsp_ovf, rsp_zero, rsp_ill, rsp_trap};
      req_funct  = nx.funct;
      req_a      = nx.a;
      req_b      = nx.b;
      req_valid  = 1'b1;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        chk($sformatf("bp_hold_valid%0d", k), W'(rsp_valid), W'(1));
        chk($sformatf("bp_hold_res%0d", k), rsp_res, held_res);
        chk($sformatf("bp_hold_flags%0d", k),
            W'({rsp_ovf, rsp_zero, rsp_ill, rsp_trap}), W'(held_flags));
        chk($sformatf("bp_req_ready%0d", k), W'(req_ready), W'(0));
      end
      chk("bp_alu_a_unchanged", alu_a, bp.a);
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("bp_after_hs_valid", W'(rsp_valid), W'(0));
      chk("bp_after_hs_ready", W'(req_ready), W'(1));
      // The still-asserted request is accepted at the next edge.
      sbq.push_back(make_exp(nx));
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      chk("bp_next_alu_op", W'(alu_op), W'(nx.op));
      collect("bp_next");
      @(negedge clk);
    end

    // Reset for one cycle mid-EXEC drops the request.
    begin
      vec_t rv = '{6'h25, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'hFFFFFFFF, 1'b0, 1'b0, 3'b001};
      issue(rv);
      void'(sbq.pop_back());
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("mid_rst_req_ready", W'(req_ready), W'(0));
      chk("mid_rst_alu_a",     alu_a,         '0);
      chk("mid_rst_alu_op",    W'(alu_op),    W'(0));
      chk("mid_rst_rsp_res",   rsp_res,       '0);
      chk("mid_rst_flags", W'({rsp_valid, rsp_ovf, rsp_zero, rsp_ill, rsp_trap}), W'(0));
      rst_n = 1'b1;
      @(negedge clk);
      chk("mid_rst_idle", W'(req_ready), W'(1));
      begin
        int seen = 0;
        for (int k = 0; k < 8; k++) begin
          @(negedge clk);
          if (rsp_valid) seen++;
        end
        chk("mid_rst_no_rsp", W'(seen), W'(0));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
